// File: rtl/bitty_pkg.sv
// Shared types and constants for the Bitty control unit: FSM states, format codes,
// operand-mux select codes and instruction field positions.
package bitty_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_WRITE  = 3'd3,
        S_ERR    = 3'd4
    } state_e;

    localparam int INSTR_W  = 16;
    localparam int NUM_REGS = 8;

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;

    localparam logic [3:0] MUX_SEL_IMM = 4'd8;
    localparam logic [3:0] MUX_SEL_DEF = 4'd9;

    localparam int RX_LSB  = 13;
    localparam int RY_LSB  = 10;
    localparam int IMM_LSB = 5;
    localparam int ALU_LSB = 2;
    localparam int FMT_LSB = 0;

endpackage

// File: rtl/bitty_instr_decode.sv
// Combinational field extraction and immediate extension from the instruction register.
// BITTY_IMM_SIGNEXT_EN selects sign extension of imm8; default is zero extension.
module bitty_instr_decode
    import bitty_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic [INSTR_W-1:0] ir,
    output logic [2:0]         rx,
    output logic [2:0]         ry,
    output logic [2:0]         alu_sel,
    output logic [1:0]         fmt,
    output logic [DATA_W-1:0]  imm_ext
);

    logic [IMM_W-1:0] imm;

    assign rx      = ir[RX_LSB  +: 3];
    assign ry      = ir[RY_LSB  +: 3];
    assign alu_sel = ir[ALU_LSB +: 3];
    assign fmt     = ir[FMT_LSB +: 2];
    assign imm     = ir[IMM_LSB +: IMM_W];

`ifdef BITTY_IMM_SIGNEXT_EN
    assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
`else
    assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
`endif

endmodule

// File: rtl/bitty_control_unit.sv
// Multi-cycle Bitty control FSM: one instruction per valid/ready handshake, outputs in
// the three cycles after it (ERR: one cycle). Ready only in IDLE. Macro: BITTY_IMM_SIGNEXT_EN.
module bitty_control_unit
    import bitty_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 4,
    parameter int IMM_W  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic [SEL_W-1:0]    mux_sel,
    output logic [DATA_W-1:0]   immediate,
    output logic [2:0]          alu_sel,
    output logic                en_s,
    output logic                en_c,
    output logic [NUM_REGS-1:0] en_reg,
    output logic                done,
    output logic                illegal
);

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   ir_q;
    logic                 ready_q, ready_d;
    logic [SEL_W-1:0]     mux_sel_q, mux_sel_d;
    logic [2:0]           alu_sel_q, alu_sel_d;
    logic                 en_s_q, en_s_d;
    logic                 en_c_q, en_c_d;
    logic [NUM_REGS-1:0]  en_reg_q, en_reg_d;
    logic                 done_q, done_d;
    logic                 illegal_q, illegal_d;
    logic                 handshake;

    logic [2:0]           dec_rx, dec_ry, dec_alu;
    logic [1:0]           dec_fmt;
    logic [DATA_W-1:0]    dec_imm;

    bitty_instr_decode #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_decode (
        .ir      (ir_q),
        .rx      (dec_rx),
        .ry      (dec_ry),
        .alu_sel (dec_alu),
        .fmt     (dec_fmt),
        .imm_ext (dec_imm)
    );

    assign handshake = instr_valid & ready_q;

    // Outputs are registered from the next state, so they line up with the state they belong to.
    // Entering LOAD_A the IR is not yet loaded, hence rx comes straight from the incoming word.
    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        mux_sel_d = SEL_W'(MUX_SEL_DEF);
        alu_sel_d = 3'd0;
        en_s_d    = 1'b0;
        en_c_d    = 1'b0;
        en_reg_d  = '0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    if (instr[FMT_LSB+1]) begin
                        state_d   = S_ERR;
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
                    end else begin
                        state_d   = S_LOAD_A;
                        mux_sel_d = SEL_W'(instr[RX_LSB +: 3]);
                        en_s_d    = 1'b1;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_LOAD_A: begin
                state_d   = S_LOAD_B;
                mux_sel_d = (dec_fmt == FMT_I) ? SEL_W'(MUX_SEL_IMM) : SEL_W'(dec_ry);
                alu_sel_d = dec_alu;
                en_c_d    = 1'b1;
            end
            S_LOAD_B: begin
                state_d  = S_WRITE;
                en_reg_d = NUM_REGS'(1) << dec_rx;
                done_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            ready_q   <= 1'b1;
            mux_sel_q <= SEL_W'(MUX_SEL_DEF);
            alu_sel_q <= 3'd0;
            en_s_q    <= 1'b0;
            en_c_q    <= 1'b0;
            en_reg_q  <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (handshake) begin
                ir_q <= instr;
            end
            ready_q   <= ready_d;
            mux_sel_q <= mux_sel_d;
            alu_sel_q <= alu_sel_d;
            en_s_q    <= en_s_d;
            en_c_q    <= en_c_d;
            en_reg_q  <= en_reg_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr_ready = ready_q;
    assign mux_sel     = mux_sel_q;
    assign immediate   = dec_imm;
    assign alu_sel     = alu_sel_q;
    assign en_s        = en_s_q;
    assign en_c        = en_c_q;
    assign en_reg      = en_reg_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_bitty_control_unit.sv
// Randomized self-checking bench for bitty_control_unit against a per-cycle reference table.
// Honours BITTY_IMM_SIGNEXT_EN for the expected immediate.
module tb_bitty_control_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  mux_sel;
    logic [15:0] immediate;
    logic [2:0]  alu_sel;
    logic        en_s;
    logic        en_c;
    logic [7:0]  en_reg;
    logic        done;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        ready;
        logic [3:0]  mux;
        logic [15:0] imm;
        logic [2:0]  alu;
        logic        en_s;
        logic        en_c;
        logic [7:0]  en_reg;
        logic        done;
        logic        illegal;
    } obs_t;

    bitty_control_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .mux_sel     (mux_sel),
        .immediate   (immediate),
        .alu_sel     (alu_sel),
        .en_s        (en_s),
        .en_c        (en_c),
        .en_reg      (en_reg),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t o;
        o.ready   = instr_ready;
        o.mux     = mux_sel;
        o.imm     = immediate;
        o.alu     = alu_sel;
        o.en_s    = en_s;
        o.en_c    = en_c;
        o.en_reg  = en_reg;
        o.done    = done;
        o.illegal = illegal;
        return o;
    endfunction

    function automatic logic [15:0] ext_imm(input logic [7:0] imm8);
`ifdef BITTY_IMM_SIGNEXT_EN
        return {{8{imm8[7]}}, imm8};
`else
        return {8'h00, imm8};
`endif
    endfunction

    function automatic obs_t reset_obs();
        obs_t o = '0;
        o.ready = 1'b1;
        o.mux   = 4'd9;
        return o;
    endfunction

    // Expected outputs k cycles after the handshake that accepted w (k=1 is the first cycle).
    function automatic obs_t model(input logic [15:0] w, input int k);
        obs_t       o;
        int         rx   = int'(w[15:13]);
        int         ry   = int'(w[12:10]);
        int         fmt  = int'(w[1:0]);
        o       = '0;
        o.mux   = 4'd9;
        o.imm   = ext_imm(w[12:5]);
        if (fmt >= 2) begin
            if (k == 1) begin
                o.done    = 1'b1;
                o.illegal = 1'b1;
            end else begin
                o.ready = 1'b1;
            end
        end else begin
            if (k == 1) begin
                o.mux  = 4'(rx);
                o.en_s = 1'b1;
            end else if (k == 2) begin
                o.mux  = (fmt == 1) ? 4'd8 : 4'(ry);
                o.alu  = w[4:2];
                o.en_c = 1'b1;
            end else if (k == 3) begin
                o.en_reg = 8'(1 << rx);
                o.done   = 1'b1;
            end else begin
                o.ready = 1'b1;
            end
        end
        return o;
    endfunction

    function automatic int steps_of(input logic [15:0] w);
        return (w[1] == 1'b1) ? 2 : 4;
    endfunction

    // Waits (bounded) for ready, presents w for one handshake and returns #1 after that edge.
    task automatic send(input logic [15:0] w);
        int guard = 0;
        while (instr_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_ready_timeout: ready=%b required 1", instr_ready);
        end
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'($urandom);
    endtask

    task automatic test_reset();
        obs_t got;
        logic [15:0] w = 16'b010_011_00000_000_00;
        got = sample();
        n_cmp++;
        if (got !== reset_obs()) begin
            n_err++;
            $display("FAIL reset_initial: got %h required %h", got, reset_obs());
        end
        send(w);
        @(negedge clk);
        @(negedge clk);
        got = sample();
        n_cmp++;
        if (got !== model(w, 2)) begin
            n_err++;
            $display("FAIL reset_pre_loadb: got %h required %h", got, model(w, 2));
        end
        reset_n = 1'b0;
        #1;
        got = sample();
        n_cmp++;
        if (got !== reset_obs()) begin
            n_err++;
            $display("FAIL reset_async_loadb: got %h required %h", got, reset_obs());
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            got = sample();
            n_cmp++;
            if (got !== reset_obs()) begin
                n_err++;
                $display("FAIL reset_after_release[%0d]: got %h required %h", k, got, reset_obs());
            end
        end
    endtask

    task automatic test_rtype();
        obs_t got;
        logic [15:0] w;
        for (int n = 0; n < 6; n++) begin
            if (n == 0) w = 16'b010_011_00000_000_00;
            else        w = {16'($urandom)} & 16'hFFFC;
            send(w);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                got = sample();
                n_cmp++;
                if (got !== model(w, k)) begin
                    n_err++;
                    $display("FAIL rtype instr=%h step=%0d: got %h required %h", w, k, got, model(w, k));
                end
            end
        end
    endtask

    task automatic test_itype();
        obs_t got;
        logic [15:0] w;
        for (int n = 0; n < 6; n++) begin
            if (n == 0) w = {3'd1, 8'hF0, 3'd3, 2'b01};
            else        w = {16'($urandom)} & 16'hFFFC | 16'h0001;
            send(w);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                got = sample();
                n_cmp++;
                if (got !== model(w, k)) begin
                    n_err++;
                    $display("FAIL itype instr=%h step=%0d: got %h required %h", w, k, got, model(w, k));
                end
            end
        end
    endtask

    task automatic test_illegal();
        obs_t got;
        logic [15:0] w;
        for (int n = 0; n < 4; n++) begin
            w = ({16'($urandom)} & 16'hFFFC) | 16'(2 + (n % 2));
            send(w);
            for (int k = 1; k <= 2; k++) begin
                @(negedge clk);
                got = sample();
                n_cmp++;
                if (got !== model(w, k)) begin
                    n_err++;
                    $display("FAIL illegal instr=%h step=%0d: got %h required %h", w, k, got, model(w, k));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got;
        logic [15:0] w1 = ({16'($urandom)} & 16'hFFFC);
        logic [15:0] w2 = ({16'($urandom)} & 16'hFFFC) | 16'h0001;
        @(negedge clk);
        instr       = w1;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr = w2;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            got = sample();
            n_cmp++;
            if (got !== model(w1, k)) begin
                n_err++;
                $display("FAIL b2b_first step=%0d: got %h required %h", k, got, model(w1, k));
            end
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            got = sample();
            n_cmp++;
            if (got !== model(w2, k)) begin
                n_err++;
                $display("FAIL b2b_second step=%0d: got %h required %h", k, got, model(w2, k));
            end
        end
    endtask

    task automatic test_mid_change();
        obs_t got;
        for (int n = 0; n < 4; n++) begin
            logic [15:0] w = ({16'($urandom)} & 16'hFFFC) | 16'(n % 2);
            send(w);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                got = sample();
                n_cmp++;
                if (got !== model(w, k)) begin
                    n_err++;
                    $display("FAIL mid_change instr=%h step=%0d: got %h required %h", w, k, got, model(w, k));
                end
                if (k == 1) begin
                    instr       = ~w;
                    instr_valid = 1'b1;
                end else if (k == 3) begin
                    instr_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic test_random();
        obs_t got;
        logic [15:0] w;
        for (int n = 0; n < 40; n++) begin
            w = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(w);
            for (int k = 1; k <= steps_of(w); k++) begin
                @(negedge clk);
                got = sample();
                n_cmp++;
                if (got !== model(w, k)) begin
                    n_err++;
                    $display("FAIL random instr=%h step=%0d: got %h required %h", w, k, got, model(w, k));
                end
            end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_rtype();
        test_itype();
        test_illegal();
        test_back_to_back();
        test_mid_change();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
